// File: rtl/br_pred_pkg.sv
// Shared constants for the branch predictor: misprediction codes, mode
// selectors and the saturating-counter reset value.
package br_pred_pkg;

  localparam logic [1:0] PRED_OK     = 2'b00;
  localparam logic [1:0] PRED_NT_ERR = 2'b01;
  localparam logic [1:0] PRED_T_ERR  = 2'b10;

  localparam int MODE_BTB = 0;
  localparam int MODE_BHT = 1;

  // Weakly-not-taken start point; a 1-bit counter simply starts at 0.
  function automatic int ctr_init(input int ctr_w);
    if (ctr_w <= 1) return 0;
    return (2 ** (ctr_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of saturating up/down counters with one combinational read port
// and one increment/decrement write port; synchronous active-high reset.
module sat_counter_table
  import br_pred_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int CTR_W = 2,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_inc
);

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(ctr_init(CTR_W));

  logic [CTR_W-1:0] ctr_q [DEPTH];
  logic [CTR_W-1:0] ctr_d [DEPTH];

  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      if (wr_inc) begin
        if (ctr_q[wr_idx] != CTR_MAX) ctr_d[wr_idx] = ctr_q[wr_idx] + 1'b1;
      end else begin
        if (ctr_q[wr_idx] != '0) ctr_d[wr_idx] = ctr_q[wr_idx] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RST;
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor_unit.sv
// Direct-mapped BTB plus BHT branch predictor: predicts in IF from registered
// tables, resolves and updates in EX, and counts branches and mispredictions.
module branch_predictor_unit
  import br_pred_pkg::*;
#(
  parameter int TABLE_LEN = 4,
  parameter int BHT_LEN   = 6,
  parameter int CTR_W     = 2,
  parameter int MODE      = 1,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pcf,
  output logic              pred_f,
  output logic [31:0]       npc_pred_f,
  input  logic [31:0]       pce,
  input  logic              is_br_e,
  input  logic              upd_en_e,
  input  logic              branch_e,
  input  logic [31:0]       br_npc_e,
  input  logic              pred_e,
  input  logic [31:0]       npc_pred_e,
  output logic [1:0]        pred_err_e,
  output logic [STAT_W-1:0] stat_br,
  output logic [STAT_W-1:0] stat_miss
);

  localparam int BTB_N = 2 ** TABLE_LEN;
  localparam int TAG_W = 30 - TABLE_LEN;

  logic [BTB_N-1:0] valid_q, valid_d;
  logic [BTB_N-1:0] tbit_q, tbit_d;
  logic [TAG_W-1:0] tag_q [BTB_N];
  logic [TAG_W-1:0] tag_d [BTB_N];
  logic [31:0]      tgt_q [BTB_N];
  logic [31:0]      tgt_d [BTB_N];
  logic [STAT_W-1:0] stat_br_q, stat_br_d;
  logic [STAT_W-1:0] stat_miss_q, stat_miss_d;

  logic [TABLE_LEN-1:0] f_idx, e_idx;
  logic [TAG_W-1:0]     f_tag, e_tag;
  logic [BHT_LEN-1:0]   f_bidx, e_bidx;
  logic [CTR_W-1:0]     f_ctr;
  logic                 f_hit, e_hit, upd;
  logic                 unused_bits;

  assign f_idx  = pcf[TABLE_LEN+1:2];
  assign f_tag  = pcf[31:TABLE_LEN+2];
  assign f_bidx = pcf[BHT_LEN+1:2];
  assign e_idx  = pce[TABLE_LEN+1:2];
  assign e_tag  = pce[31:TABLE_LEN+2];
  assign e_bidx = pce[BHT_LEN+1:2];
  assign unused_bits = ^{pcf[1:0], pce[1:0], f_ctr};

  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign upd   = upd_en_e & is_br_e;

  always_comb begin
    pred_f = 1'b0;
    if (MODE == MODE_BHT) pred_f = f_hit & f_ctr[CTR_W-1];
    else                  pred_f = f_hit & tbit_q[f_idx];
    npc_pred_f = pred_f ? tgt_q[f_idx] : pcf + 32'd4;
  end

  always_comb begin
    pred_err_e = PRED_OK;
    if (is_br_e) begin
      if (branch_e && (!pred_e || (npc_pred_e != br_npc_e))) pred_err_e = PRED_T_ERR;
      else if (!branch_e && pred_e)                          pred_err_e = PRED_NT_ERR;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    tbit_d      = tbit_q;
    tag_d       = tag_q;
    tgt_d       = tgt_q;
    stat_br_d   = stat_br_q;
    stat_miss_d = stat_miss_q;
    if (upd) begin
      stat_br_d = stat_br_q + STAT_W'(1);
      if (pred_err_e != PRED_OK) stat_miss_d = stat_miss_q + STAT_W'(1);
      if (branch_e) begin
        valid_d[e_idx] = 1'b1;
        tbit_d[e_idx]  = 1'b1;
        tag_d[e_idx]   = e_tag;
        tgt_d[e_idx]   = br_npc_e;
      end else if ((MODE == MODE_BTB) && e_hit) begin
        // Only the owning branch may demote the entry; an aliasing PC leaves it alone.
        tbit_d[e_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      tbit_q      <= '0;
      stat_br_q   <= '0;
      stat_miss_q <= '0;
      for (int i = 0; i < BTB_N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      tbit_q      <= tbit_d;
      tag_q       <= tag_d;
      tgt_q       <= tgt_d;
      stat_br_q   <= stat_br_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  assign stat_br   = stat_br_q;
  assign stat_miss = stat_miss_q;

  sat_counter_table #(
    .DEPTH (2 ** BHT_LEN),
    .CTR_W (CTR_W)
  ) u_bht (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (f_bidx),
    .rd_ctr (f_ctr),
    .wr_en  (upd),
    .wr_idx (e_bidx),
    .wr_inc (branch_e)
  );

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed bench: one BTB+BHT instance and one BTB-only instance share the
// EX-stage stimulus; each carries its own fetch prediction down to EX.
module tb_branch_predictor_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pcf = 32'h0;
  logic [31:0] pce = 32'h0;
  logic        is_br_e = 1'b0;
  logic        upd_en_e = 1'b0;
  logic        branch_e = 1'b0;
  logic [31:0] br_npc_e = 32'h0;

  logic        pred_f1, pred_f0;
  logic [31:0] npc_pred_f1, npc_pred_f0;
  logic        pred_e1 = 1'b0, pred_e0 = 1'b0;
  logic [31:0] npc_pred_e1 = 32'h0, npc_pred_e0 = 32'h0;
  logic [1:0]  pred_err_e1, pred_err_e0;
  logic [31:0] stat_br1, stat_miss1, stat_br0, stat_miss0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  branch_predictor_unit #(.TABLE_LEN(4), .BHT_LEN(6), .CTR_W(2), .MODE(1), .STAT_W(32)) dut1 (
    .clk(clk), .rst(rst), .pcf(pcf), .pred_f(pred_f1), .npc_pred_f(npc_pred_f1),
    .pce(pce), .is_br_e(is_br_e), .upd_en_e(upd_en_e), .branch_e(branch_e),
    .br_npc_e(br_npc_e), .pred_e(pred_e1), .npc_pred_e(npc_pred_e1),
    .pred_err_e(pred_err_e1), .stat_br(stat_br1), .stat_miss(stat_miss1)
  );

  branch_predictor_unit #(.TABLE_LEN(4), .BHT_LEN(6), .CTR_W(2), .MODE(0), .STAT_W(32)) dut0 (
    .clk(clk), .rst(rst), .pcf(pcf), .pred_f(pred_f0), .npc_pred_f(npc_pred_f0),
    .pce(pce), .is_br_e(is_br_e), .upd_en_e(upd_en_e), .branch_e(branch_e),
    .br_npc_e(br_npc_e), .pred_e(pred_e0), .npc_pred_e(npc_pred_e0),
    .pred_err_e(pred_err_e0), .stat_br(stat_br0), .stat_miss(stat_miss0)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; is_br_e = 1'b0; upd_en_e = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc);
    @(negedge clk);
    pcf = pc;
    #1;
  endtask

  // Predict at pc, then resolve the same branch in EX during that cycle.
  task automatic exec_br(input string tag, input logic [31:0] pc, input logic tk,
                         input logic [31:0] tgt, input logic [1:0] e1, input logic [1:0] e0);
    @(negedge clk);
    pcf = pc;
    #1;
    pred_e1 = pred_f1; npc_pred_e1 = npc_pred_f1;
    pred_e0 = pred_f0; npc_pred_e0 = npc_pred_f0;
    pce = pc; is_br_e = 1'b1; upd_en_e = 1'b1; branch_e = tk; br_npc_e = tgt;
    #1;
    check_val({tag, "_err1"}, {30'd0, pred_err_e1}, {30'd0, e1});
    check_val({tag, "_err0"}, {30'd0, pred_err_e0}, {30'd0, e0});
    @(posedge clk);
    #1;
    is_br_e = 1'b0; upd_en_e = 1'b0;
  endtask

  initial begin
    do_reset();

    fetch(32'h100);
    check_val("rst_pred1", {31'd0, pred_f1}, 32'd0);
    check_val("rst_npc1", npc_pred_f1, 32'h104);
    check_val("rst_pred0", {31'd0, pred_f0}, 32'd0);
    check_val("rst_br1", stat_br1, 32'd0);
    check_val("rst_miss1", stat_miss1, 32'd0);

    // Taken twice to 0x80: counter 1->2 after the first, then predicted.
    exec_br("t2a", 32'h100, 1'b1, 32'h80, 2'b10, 2'b10);
    fetch(32'h100);
    check_val("t2_pred1", {31'd0, pred_f1}, 32'd1);
    check_val("t2_npc1", npc_pred_f1, 32'h80);
    exec_br("t2b", 32'h100, 1'b1, 32'h80, 2'b00, 2'b00);
    check_val("t2_br1", stat_br1, 32'd2);
    check_val("t2_miss1", stat_miss1, 32'd1);

    // Saturation: 5 taken -> ctr 3; NT -> 2 (still taken); NT -> 1 (not taken).
    do_reset();
    exec_br("sat1", 32'h200, 1'b1, 32'h300, 2'b10, 2'b10);
    for (int i = 0; i < 4; i++) exec_br("satT", 32'h200, 1'b1, 32'h300, 2'b00, 2'b00);
    exec_br("satN1", 32'h200, 1'b0, 32'h300, 2'b01, 2'b01);
    fetch(32'h200);
    check_val("sat_pred1_ctr2", {31'd0, pred_f1}, 32'd1);
    check_val("sat_pred0_clr", {31'd0, pred_f0}, 32'd0);
    exec_br("satN2", 32'h200, 1'b0, 32'h300, 2'b01, 2'b00);
    fetch(32'h200);
    check_val("sat_pred1_ctr1", {31'd0, pred_f1}, 32'd0);
    check_val("sat_npc1_ctr1", npc_pred_f1, 32'h204);
    exec_br("satN3", 32'h200, 1'b0, 32'h300, 2'b00, 2'b00);
    check_val("sat_br1", stat_br1, 32'd8);
    check_val("sat_miss1", stat_miss1, 32'd3);

    // Loop branch: T T T N T.
    do_reset();
    exec_br("loop1", 32'h400, 1'b1, 32'h3f0, 2'b10, 2'b10);
    exec_br("loop2", 32'h400, 1'b1, 32'h3f0, 2'b00, 2'b00);
    exec_br("loop3", 32'h400, 1'b1, 32'h3f0, 2'b00, 2'b00);
    exec_br("loop4", 32'h400, 1'b0, 32'h3f0, 2'b01, 2'b01);
    exec_br("loop5", 32'h400, 1'b1, 32'h3f0, 2'b00, 2'b10);
    check_val("loop_miss0", stat_miss0, 32'd3);
    check_val("loop_br0", stat_br0, 32'd5);
    check_val("loop_miss1", stat_miss1, 32'd2);

    // BTB conflict: 0x100 and 0x140 share index 0.
    do_reset();
    exec_br("cf1", 32'h100, 1'b1, 32'h80, 2'b10, 2'b10);
    exec_br("cf2", 32'h140, 1'b1, 32'hc0, 2'b10, 2'b10);
    fetch(32'h100);
    check_val("cf_pred1_100", {31'd0, pred_f1}, 32'd0);
    check_val("cf_pred0_100", {31'd0, pred_f0}, 32'd0);
    check_val("cf_npc0_100", npc_pred_f0, 32'h104);
    fetch(32'h140);
    check_val("cf_pred0_140", {31'd0, pred_f0}, 32'd1);
    check_val("cf_npc0_140", npc_pred_f0, 32'hc0);
    check_val("cf_npc1_140", npc_pred_f1, 32'hc0);

    // Stalled EX: four cycles held, then one advancing cycle.
    do_reset();
    @(negedge clk);
    pcf = 32'h500; pce = 32'h500; is_br_e = 1'b1; upd_en_e = 1'b0;
    branch_e = 1'b1; br_npc_e = 32'h600; pred_e1 = 1'b0; pred_e0 = 1'b0;
    npc_pred_e1 = 32'h504; npc_pred_e0 = 32'h504;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("stall_err1", {30'd0, pred_err_e1}, 32'd2);
      check_val("stall_pred0", {31'd0, pred_f0}, 32'd0);
    end
    check_val("stall_br1_held", stat_br1, 32'd0);
    upd_en_e = 1'b1;
    @(negedge clk);
    is_br_e = 1'b0; upd_en_e = 1'b0;
    #1;
    check_val("stall_br1", stat_br1, 32'd1);
    check_val("stall_miss1", stat_miss1, 32'd1);
    check_val("stall_pred0_after", {31'd0, pred_f0}, 32'd1);
    check_val("stall_pred1_after", {31'd0, pred_f1}, 32'd1);

    // Reset coinciding with an update discards the update.
    @(negedge clk);
    pcf = 32'h700; pce = 32'h700; is_br_e = 1'b1; upd_en_e = 1'b1;
    branch_e = 1'b1; br_npc_e = 32'h800; pred_e0 = 1'b0; pred_e1 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; is_br_e = 1'b0; upd_en_e = 1'b0;
    #1;
    check_val("rstupd_pred0", {31'd0, pred_f0}, 32'd0);
    check_val("rstupd_npc0", npc_pred_f0, 32'h704);
    check_val("rstupd_br0", stat_br0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
